// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between two requesters.
// Port 0 is the CPU load/store path, port 1 the DMA/debug loader. A granted
// request is registered, drives the memory for exactly one ACCESS cycle,
// read data is captured at the end of ACCESS and a one-cycle Ack is returned
// in RESP.
//
// Optional feature macro: DMEM_ARB_FIXED_PRIO_EN
//   defined   -> port 0 always wins simultaneous requests
//   undefined -> round-robin between the two ports
//
// Ports:
//   Clk, Rst_n                  clock, asynchronous active-low reset
//   Px_Req/Write/Address/WriteData  request from port x (x = 0, 1)
//   Px_Ack                      one-cycle completion pulse for port x
//   Px_ReadData                 read result, held until the next read for x
//   Mem_Address/WriteData/MemWrite  memory command (registered)
//   Mem_MemData                 combinational read data from memory
//   Busy                        high while an access is in flight
module dmem_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     P0_Req,
   input  logic                     P0_Write,
   input  logic [ADDRESS_WIDTH-1:0] P0_Address,
   input  logic [DATA_WIDTH-1:0]    P0_WriteData,
   output logic                     P0_Ack,
   output logic [DATA_WIDTH-1:0]    P0_ReadData,
   input  logic                     P1_Req,
   input  logic                     P1_Write,
   input  logic [ADDRESS_WIDTH-1:0] P1_Address,
   input  logic [DATA_WIDTH-1:0]    P1_WriteData,
   output logic                     P1_Ack,
   output logic [DATA_WIDTH-1:0]    P1_ReadData,
   output logic [ADDRESS_WIDTH-1:0] Mem_Address,
   output logic [DATA_WIDTH-1:0]    Mem_WriteData,
   output logic                     Mem_MemWrite,
   input  logic [DATA_WIDTH-1:0]    Mem_MemData,
   output logic                     Busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   // Registered copy of the granted request
   typedef struct packed {
      logic                     port;
      logic                     write;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    wdata;
   } req_t;

   logic [1:0]            state, state_d;
   logic                  last_grant, last_grant_d;
   req_t                  cur, cur_d;
   logic                  mem_we_d;
   logic                  busy_d;
   logic                  ack0_d, ack1_d;
   logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;
   logic                  win_port_c;

   // Winner among current requesters (only meaningful when any Req is high)
`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign win_port_c = ~P0_Req;
`else
   assign win_port_c = (P0_Req & P1_Req) ? ~last_grant : P1_Req;
`endif

   // Memory address/data come straight from the registered request
   assign Mem_Address   = cur.addr;
   assign Mem_WriteData = cur.wdata;

   // State and output registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= S_IDLE;
         last_grant   <= 1'b1;
         cur          <= '0;
         Mem_MemWrite <= 1'b0;
         Busy         <= 1'b0;
         P0_Ack       <= 1'b0;
         P1_Ack       <= 1'b0;
         P0_ReadData  <= '0;
         P1_ReadData  <= '0;
      end else begin
         state        <= state_d;
         last_grant   <= last_grant_d;
         cur          <= cur_d;
         Mem_MemWrite <= mem_we_d;
         Busy         <= busy_d;
         P0_Ack       <= ack0_d;
         P1_Ack       <= ack1_d;
         P0_ReadData  <= rdata0_d;
         P1_ReadData  <= rdata1_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state;
      last_grant_d = last_grant;
      cur_d        = cur;
      mem_we_d     = 1'b0;
      busy_d       = Busy;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = P0_ReadData;
      rdata1_d     = P1_ReadData;

      case (state)
         S_IDLE: begin
            if (P0_Req || P1_Req) begin
               cur_d.port   = win_port_c;
               cur_d.write  = win_port_c ? P1_Write     : P0_Write;
               cur_d.addr   = win_port_c ? P1_Address   : P0_Address;
               cur_d.wdata  = win_port_c ? P1_WriteData : P0_WriteData;
               last_grant_d = win_port_c;
               // Write strobe is high only during the ACCESS cycle
               mem_we_d     = cur_d.write;
               busy_d       = 1'b1;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // Memory read is combinational; capture it at the end of ACCESS
            if (!cur.write) begin
               if (cur.port) rdata1_d = Mem_MemData;
               else          rdata0_d = Mem_MemData;
            end
            ack0_d  = ~cur.port;
            ack1_d  = cur.port;
            busy_d  = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and an
// expected-response scoreboard popped on every Ack.
module tb_dmem_arbiter;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        P0_Req, P0_Write, P1_Req, P1_Write;
   logic [15:0] P0_Address, P1_Address;
   logic [31:0] P0_WriteData, P1_WriteData;
   logic        P0_Ack, P1_Ack;
   logic [31:0] P0_ReadData, P1_ReadData;
   logic [15:0] Mem_Address;
   logic [31:0] Mem_WriteData;
   logic        Mem_MemWrite;
   logic [31:0] Mem_MemData;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        port;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   logic [31:0] mem [0:65535];

   always #5 Clk = ~Clk;

   dmem_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .P0_Req(P0_Req), .P0_Write(P0_Write), .P0_Address(P0_Address),
      .P0_WriteData(P0_WriteData), .P0_Ack(P0_Ack), .P0_ReadData(P0_ReadData),
      .P1_Req(P1_Req), .P1_Write(P1_Write), .P1_Address(P1_Address),
      .P1_WriteData(P1_WriteData), .P1_Ack(P1_Ack), .P1_ReadData(P1_ReadData),
      .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
      .Mem_MemWrite(Mem_MemWrite), .Mem_MemData(Mem_MemData), .Busy(Busy)
   );

   // Single-port memory: combinational read, write on posedge
   assign Mem_MemData = mem[Mem_Address];
   always @(posedge Clk) begin
      if (Mem_MemWrite) mem[Mem_Address] = Mem_WriteData;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every Ack must match the oldest outstanding expectation
   always @(negedge Clk) begin : monitor
      exp_t e;
      if (Rst_n === 1'b1 && (P0_Ack === 1'b1 || P1_Ack === 1'b1)) begin
         chk("ack_onehot", 64'(P0_Ack & P1_Ack), 64'd0);
         if (sb.size() == 0) begin
            chk("ack_unexpected", 64'({P0_Ack, P1_Ack}), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_port", 64'(P1_Ack), 64'(e.port));
            if (e.chk_data)
               chk("ack_rdata", 64'(P1_Ack ? P1_ReadData : P0_ReadData), 64'(e.data));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_acks(input int n);
      int seen = 0;
      for (int c = 0; c < 60 && seen < n; c++) begin
         @(negedge Clk);
         if (P0_Ack === 1'b1 || P1_Ack === 1'b1) seen++;
      end
      chk("ack_count", 64'(seen), 64'(n));
   endtask

   initial begin : stim
      for (int i = 0; i < 65536; i++) mem[i] = {16'hA500, 16'(i)};
      Rst_n = 1'b0;
      P0_Req = 0; P0_Write = 0; P0_Address = '0; P0_WriteData = '0;
      P1_Req = 0; P1_Write = 0; P1_Address = '0; P1_WriteData = '0;

      // Reset state
      repeat (3) @(negedge Clk);
      chk("rst_ctrl", 64'({Busy, P0_Ack, P1_Ack, Mem_MemWrite}), 64'd0);
      chk("rst_rdata", 64'({P0_ReadData, P1_ReadData}), 64'd0);
      chk("rst_mem_bus", 64'({Mem_Address, Mem_WriteData}), 64'd0);
      Rst_n = 1'b1;

      // Port 0 write 0xDEADBEEF to 0x0004
      @(posedge Clk); #1;
      P0_Req = 1; P0_Write = 1; P0_Address = 16'h0004; P0_WriteData = 32'hDEADBEEF;
      sb.push_back('{port: 1'b0, chk_data: 1'b0, data: 32'h0});
      @(posedge Clk); #1;
      P0_Req = 0; P0_Write = 0;
      @(negedge Clk);
      chk("wr_access_we", 64'(Mem_MemWrite), 64'd1);
      chk("wr_access_addr", 64'(Mem_Address), 64'h0004);
      chk("wr_access_data", 64'(Mem_WriteData), 64'hDEADBEEF);
      chk("wr_access_busy_ack", 64'({Busy, P0_Ack}), 64'b10);
      @(negedge Clk);
      chk("wr_resp", 64'({P0_Ack, P1_Ack, Mem_MemWrite, Busy}), 64'b1001);
      @(negedge Clk);
      chk("wr_done", 64'({P0_Ack, Busy}), 64'd0);
      chk("wr_mem", 64'(mem[16'h0004]), 64'hDEADBEEF);

      // Port 1 read of the same address
      @(posedge Clk); #1;
      P1_Req = 1; P1_Write = 0; P1_Address = 16'h0004;
      sb.push_back('{port: 1'b1, chk_data: 1'b1, data: 32'hDEADBEEF});
      @(posedge Clk); #1;
      P1_Req = 0;
      @(negedge Clk);
      chk("rd_access_we", 64'(Mem_MemWrite), 64'd0);
      @(negedge Clk);
      chk("rd_resp_acks", 64'({P0_Ack, P1_Ack, Mem_MemWrite}), 64'b010);
      chk("rd_resp_data", 64'(P1_ReadData), 64'hDEADBEEF);
      @(negedge Clk);
      chk("rd_hold_data", 64'(P1_ReadData), 64'hDEADBEEF);
      chk("rd_hold_ack", 64'(P1_Ack), 64'd0);

      // Contention from reset: both ports held for four accesses
      @(posedge Clk); #1; Rst_n = 1'b0;
      @(posedge Clk); #1; Rst_n = 1'b1;
      P0_Req = 1; P0_Write = 0; P0_Address = 16'h0010;
      P1_Req = 1; P1_Write = 0; P1_Address = 16'h0020;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++)
         sb.push_back('{port: 1'b0, chk_data: 1'b1, data: 32'hA5000010});
`else
      for (int k = 0; k < 4; k++)
         sb.push_back('{port: 1'(k % 2), chk_data: 1'b1,
                        data: (k % 2) ? 32'hA5000020 : 32'hA5000010});
`endif
      wait_acks(4);
      @(posedge Clk); #1;
      P0_Req = 0; P1_Req = 0;
      repeat (2) @(negedge Clk);
      chk("cont_idle", 64'(Busy), 64'd0);
      chk("cont_sb_drained", 64'(sb.size()), 64'd0);

      // Port 1 write aborted by reset during ACCESS
      @(posedge Clk); #1;
      P1_Req = 1; P1_Write = 1; P1_Address = 16'h0030; P1_WriteData = 32'h12345678;
      @(posedge Clk); #1;
      P1_Req = 0; P1_Write = 0;
      #2;
      chk("abort_we_before", 64'(Mem_MemWrite), 64'd1);
      Rst_n = 1'b0;
      #1;
      chk("abort_we_after", 64'({Mem_MemWrite, Busy}), 64'd0);
      @(negedge Clk);
      chk("abort_no_ack", 64'({P0_Ack, P1_Ack, Busy}), 64'd0);
      chk("abort_mem", 64'(mem[16'h0030]), 64'hA5000030);
      @(posedge Clk); #1; Rst_n = 1'b1;
      @(posedge Clk); #1;
      P0_Req = 1; P0_Write = 0; P0_Address = 16'h0030;
      sb.push_back('{port: 1'b0, chk_data: 1'b1, data: 32'hA5000030});
      @(posedge Clk); #1;
      P0_Req = 0;
      wait_acks(1);

      // Address changed after grant must not affect the access
      @(posedge Clk); #1;
      P0_Req = 1; P0_Write = 0; P0_Address = 16'h0010;
      sb.push_back('{port: 1'b0, chk_data: 1'b1, data: 32'hA5000010});
      @(posedge Clk); #1;
      P0_Address = 16'h0020; P0_Req = 0;
      @(negedge Clk);
      chk("late_addr", 64'(Mem_Address), 64'h0010);
      @(negedge Clk);
      chk("late_rdata", 64'(P0_ReadData), 64'hA5000010);

      // Idle with no requests
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         chk("idle_quiet", 64'({Busy, P0_Ack, P1_Ack, Mem_MemWrite}), 64'd0);
      end
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-port data memory (combinational read, write on posedge when MemWrite is high) between two requesters. Port 0 is the CPU load/store path and port 1 is the DMA/debug loader. The block registers each granted request, drives the memory for exactly one cycle, captures read data and returns a one-cycle Ack. It sits between the requesters and the data memory instance.

Parameters:
ADDRESS_WIDTH, 16, memory address width; must match the data memory.
DATA_WIDTH, 32, data word width; must match the data memory.

Ports:
Clk  input  1  clock; all state updates on posedge
Rst_n  input  1  asynchronous active-low reset
P0_Req  input  1  port 0 request; held high until P0_Ack
P0_Write  input  1  port 0: 1 = write, 0 = read
P0_Address  input  ADDRESS_WIDTH  port 0 address
P0_WriteData  input  DATA_WIDTH  port 0 write data
P0_Ack  output  1  port 0 one-cycle completion pulse
P0_ReadData  output  DATA_WIDTH  port 0 read result; valid while P0_Ack is high, held afterwards
P1_Req, P1_Write, P1_Address, P1_WriteData, P1_Ack, P1_ReadData  same as port 0, for port 1
Mem_Address  output  ADDRESS_WIDTH  to memory Address
Mem_WriteData  output  DATA_WIDTH  to memory WriteData
Mem_MemWrite  output  1  to memory MemWrite
Mem_MemData  input  DATA_WIDTH  from memory MemData
Busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE, all Acks 0, Mem_MemWrite 0, Busy 0, P0/P1_ReadData 0, Mem_Address 0, Mem_WriteData 0, last_grant=1 (port 0 wins first). Reset mid-access abandons the access; no write is issued after reset asserts.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If no Req, stay in IDLE.
  - If any Req, pick the winner and register the winner's address, write data, write flag and port id. Update last_grant to the winner. Go to ACCESS.
- Arbitration (default, round-robin):
  - Single requester wins.
  - If both request, the port != last_grant wins.
- ACCESS (one cycle):
  - Mem_Address and Mem_WriteData come from the registered values.
  - Mem_MemWrite = registered write flag. It is never high outside ACCESS, so the write lands on the posedge that ends ACCESS.
  - For a read, Mem_MemData is captured at the same edge into the winner's ReadData.
  - For a write, ReadData is unchanged.
  - Go to RESP.
- RESP: winner's Ack=1 for exactly one cycle, loser's Ack=0; Req inputs are ignored in RESP. Go to IDLE.
- Latency: Req sampled at edge N -> ACCESS in cycle N+1 -> Ack in cycle N+2. Peak throughput is 1 access per 3 cycles.
- Requester rules:
  - A requester must drop Req at the edge ending its Ack cycle, or keep it high to request again.
  - Req held high continuously yields back-to-back accesses. Under contention the ports alternate.
- Requester inputs may change freely after the IDLE->ACCESS edge (they are already registered).
- Address wrap: none; the address passes straight through. Out-of-range behaviour is the memory's.
- Busy = (state != IDLE).

Optional Feature:
DMEM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins simultaneous requests. last_grant is still updated but not used in arbitration. Port 1 can starve while P0_Req is held high. When undefined, round-robin as above.

Test Plan:
- Port 0 writes 0xDEADBEEF to addr 0x0004. Reset released, P0_Req=1, P0_Write=1 -> Mem_MemWrite high exactly one cycle (ACCESS) with Mem_Address=0x0004; P0_Ack is a single pulse 2 cycles after Req is sampled.
- Port 1 reads addr 0x0004 after that write -> P1_ReadData=0xDEADBEEF when P1_Ack=1; Mem_MemWrite stays 0; P0_Ack stays 0.
- Both ports request reads at the same edge from reset -> port 0 acked first, then port 1. With both held high over 4 accesses the Ack order is 0,1,0,1. With DMEM_ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- Write request on port 1 with Rst_n pulsed low during ACCESS, before the posedge -> Mem_MemWrite drops immediately, no Ack, state IDLE. A later read of that address returns the prior contents.
- Port 0 changes P0_Address from 0x0010 to 0x0020 one cycle after grant -> the access uses 0x0010.
- Idle with no Req for 10 cycles -> Busy=0, Acks=0, Mem_MemWrite=0 throughout.
